// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage.
//   fetch_state_t : fetch sequencer states
//   NOP_INSTR     : instruction shown to decode when nothing is buffered
//                   (addi x0,x0,0)
package riscv_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      DROP = 3'd4
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller. It sequences the PC register and the instruction
// memory port, keeps at most one imem request outstanding, buffers the
// returned instruction for decode, and handles branch/jump redirects,
// including discarding responses that belong to abandoned requests.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   pc_i                current PC from the PC register
//   pc_stall_o          hold the PC register
//   pc_src_o            PC register loads pc_target_o instead of pc+4
//   pc_target_o         word-aligned redirect target
//   imem_req_o/addr_o   fetch request and address
//   imem_gnt_i          request accepted this cycle
//   imem_rvalid_i/rdata response (in order, at least one cycle after grant)
//   redirect_i/target_i taken branch/jump pulse from execute
//   dec_valid_o/instr_o/pc_o/ready_i  buffered instruction to decode
//   drop_cnt_o          saturating count of discarded responses
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | one bubble after reset, no request
// REQ   | request presented at pc_i, waiting for grant
// WAIT  | request granted, waiting for its response
// HOLD  | instruction buffered, waiting for decode to accept
// DROP  | a stale request is outstanding, its response will be discarded
module fetch_ctrl
   import riscv_pkg::*;
#(
   parameter int                 XLEN      = 32,
   parameter logic [XLEN-1:0]    NOP_INSTR = riscv_pkg::NOP_INSTR,
   parameter int                 CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   pc_i,
   output logic              pc_stall_o,
   output logic              pc_src_o,
   output logic [XLEN-1:0]   pc_target_o,
   output logic              imem_req_o,
   output logic [XLEN-1:0]   imem_addr_o,
   input  logic              imem_gnt_i,
   input  logic              imem_rvalid_i,
   input  logic [XLEN-1:0]   imem_rdata_i,
   input  logic              redirect_i,
   input  logic [XLEN-1:0]   redirect_target_i,
   output logic              dec_valid_o,
   output logic [XLEN-1:0]   dec_instr_o,
   output logic [XLEN-1:0]   dec_pc_o,
   input  logic              dec_ready_i,
   output logic [CNT_W-1:0]  drop_cnt_o
);

   fetch_state_t     state;
   fetch_state_t     state_nxt;
   logic [XLEN-1:0]  fetch_addr;
   logic             drop_inc;
   logic             unused_target_lsbs;

   assign unused_target_lsbs = ^redirect_target_i[1:0];

   // A response is thrown away either while waiting out a stale request, or
   // when it arrives in the same cycle a redirect kills the current fetch.
   assign drop_inc = imem_rvalid_i &&
                     ((state == DROP) || ((state == WAIT) && redirect_i));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: state_nxt = REQ;
         REQ: begin
            if (imem_gnt_i) begin
               state_nxt = redirect_i ? DROP : WAIT;
            end else begin
               state_nxt = REQ;
            end
         end
         WAIT: begin
            if (redirect_i) begin
               state_nxt = imem_rvalid_i ? REQ : DROP;
            end else if (imem_rvalid_i) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (redirect_i || dec_ready_i) begin
               state_nxt = REQ;
            end
         end
         DROP: begin
            // A second redirect here only reloads the PC; the one stale
            // response is still pending.
            if (imem_rvalid_i) begin
               state_nxt = REQ;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      imem_req_o  = 1'b0;
      imem_addr_o = pc_i;
      pc_src_o    = 1'b0;
      pc_stall_o  = 1'b1;
      pc_target_o = {redirect_target_i[XLEN-1:2], 2'b00};
      if (rst_n) begin
         imem_req_o = (state == REQ);
         pc_src_o   = redirect_i;
         pc_stall_o = !(redirect_i || ((state == REQ) && imem_gnt_i));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_addr  <= '0;
         dec_valid_o <= 1'b0;
         dec_instr_o <= NOP_INSTR;
         dec_pc_o    <= '0;
         drop_cnt_o  <= '0;
      end else begin
         if ((state == REQ) && imem_gnt_i) begin
            fetch_addr <= pc_i;
         end

         if (redirect_i) begin
            dec_valid_o <= 1'b0;
            dec_instr_o <= NOP_INSTR;
         end else if ((state == WAIT) && imem_rvalid_i) begin
            dec_valid_o <= 1'b1;
            dec_instr_o <= imem_rdata_i;
            dec_pc_o    <= fetch_addr;
         end else if ((state == HOLD) && dec_ready_i) begin
            dec_valid_o <= 1'b0;
            dec_instr_o <= NOP_INSTR;
         end

         if (drop_inc && (drop_cnt_o != {CNT_W{1'b1}})) begin
            drop_cnt_o <= drop_cnt_o + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

   localparam int XLEN  = 32;
   localparam int CNT_W = 3;

   logic              clk;
   logic              rst_n;
   logic [XLEN-1:0]   pc;
   logic              pc_stall_o;
   logic              pc_src_o;
   logic [XLEN-1:0]   pc_target_o;
   logic              imem_req_o;
   logic [XLEN-1:0]   imem_addr_o;
   logic              imem_gnt_i;
   logic              imem_rvalid_i;
   logic [XLEN-1:0]   imem_rdata_i;
   logic              redirect_i;
   logic [XLEN-1:0]   redirect_target_i;
   logic              dec_valid_o;
   logic [XLEN-1:0]   dec_instr_o;
   logic [XLEN-1:0]   dec_pc_o;
   logic              dec_ready_i;
   logic [CNT_W-1:0]  drop_cnt_o;

   int errors = 0;
   int checks = 0;

   fetch_ctrl #(.XLEN(XLEN), .NOP_INSTR(32'h0000_0013), .CNT_W(CNT_W)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .pc_i              (pc),
      .pc_stall_o        (pc_stall_o),
      .pc_src_o          (pc_src_o),
      .pc_target_o       (pc_target_o),
      .imem_req_o        (imem_req_o),
      .imem_addr_o       (imem_addr_o),
      .imem_gnt_i        (imem_gnt_i),
      .imem_rvalid_i     (imem_rvalid_i),
      .imem_rdata_i      (imem_rdata_i),
      .redirect_i        (redirect_i),
      .redirect_target_i (redirect_target_i),
      .dec_valid_o       (dec_valid_o),
      .dec_instr_o       (dec_instr_o),
      .dec_pc_o          (dec_pc_o),
      .dec_ready_i       (dec_ready_i),
      .drop_cnt_o        (drop_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PC register the controller drives
   always @(posedge clk) begin
      if (!rst_n)              pc <= '0;
      else if (!pc_stall_o)    pc <= pc_src_o ? pc_target_o : pc + 32'd4;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic gnt, input logic rv, input logic [31:0] rdata,
                      input logic redir, input logic [31:0] tgt, input logic rdy);
      imem_gnt_i        = gnt;
      imem_rvalid_i     = rv;
      imem_rdata_i      = rdata;
      redirect_i        = redir;
      redirect_target_i = tgt;
      dec_ready_i       = rdy;
      #1;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drv(0, 0, 32'h0, 1, 32'h44, 0);
      adv();
      adv();
      // reset held, redirect asserted: must not reach the PC register
      drv(0, 0, 32'h0, 1, 32'h44, 0);
      chk("rst_valid", {31'b0, dec_valid_o}, 32'h0);
      chk("rst_instr", dec_instr_o, 32'h13);
      chk("rst_req", {31'b0, imem_req_o}, 32'h0);
      chk("rst_drop", {29'b0, drop_cnt_o}, 32'h0);
      chk("rst_stall", {31'b0, pc_stall_o}, 32'h1);
      chk("rst_src", {31'b0, pc_src_o}, 32'h0);
      chk("rst_pcpc", {29'b0, dec_pc_o[2:0]} | dec_pc_o, 32'h0);

      rst_n = 1'b1;
      drv(0, 0, 32'h0, 0, 32'h0, 1);            // IDLE bubble
      chk("idle_req", {31'b0, imem_req_o}, 32'h0);
      adv();

      // straight line: addr 0
      drv(1, 0, 32'h0, 0, 32'h0, 1);
      chk("req0", {31'b0, imem_req_o}, 32'h1);
      chk("addr0", imem_addr_o, 32'h0);
      chk("gnt_stall0", {31'b0, pc_stall_o}, 32'h0);
      adv();
      drv(0, 1, 32'h0010_0093, 0, 32'h0, 1);    // WAIT, response
      chk("wait_req", {31'b0, imem_req_o}, 32'h0);
      chk("wait_stall", {31'b0, pc_stall_o}, 32'h1);
      adv();
      drv(0, 0, 32'h0, 0, 32'h0, 1);            // HOLD, decode takes it
      chk("d0_valid", {31'b0, dec_valid_o}, 32'h1);
      chk("d0_pc", dec_pc_o, 32'h0);
      chk("d0_instr", dec_instr_o, 32'h0010_0093);
      adv();
      drv(1, 0, 32'h0, 0, 32'h0, 1);            // addr 4
      chk("clr_valid", {31'b0, dec_valid_o}, 32'h0);
      chk("clr_instr", dec_instr_o, 32'h13);
      chk("addr4", imem_addr_o, 32'h4);
      adv();
      drv(0, 1, 32'h0020_0113, 0, 32'h0, 1);
      adv();
      drv(0, 0, 32'h0, 0, 32'h0, 1);
      chk("d1_pc", dec_pc_o, 32'h4);
      chk("d1_instr", dec_instr_o, 32'h0020_0113);
      adv();
      drv(1, 0, 32'h0, 0, 32'h0, 1);            // addr 8
      chk("addr8", imem_addr_o, 32'h8);
      adv();
      drv(0, 1, 32'h0030_0193, 0, 32'h0, 1);
      adv();
      drv(0, 0, 32'h0, 0, 32'h0, 0);            // HOLD, decode stalls
      chk("d2_pc", dec_pc_o, 32'h8);
      chk("d2_instr", dec_instr_o, 32'h0030_0193);
      adv();
      drv(0, 0, 32'h0, 0, 32'h0, 1);
      chk("hold_valid", {31'b0, dec_valid_o}, 32'h1);
      chk("hold_pc", dec_pc_o, 32'h8);
      chk("hold_req", {31'b0, imem_req_o}, 32'h0);
      adv();

      // grant backpressure at addr 12
      for (int i = 0; i < 4; i++) begin
         drv(0, 0, 32'h0, 0, 32'h0, 1);
         chk("bp_req", {31'b0, imem_req_o}, 32'h1);
         chk("bp_addr", imem_addr_o, 32'hC);
         chk("bp_stall", {31'b0, pc_stall_o}, 32'h1);
         chk("bp_pc", pc, 32'hC);
         adv();
      end
      drv(1, 0, 32'h0, 0, 32'h0, 1);
      chk("bp_gnt_addr", imem_addr_o, 32'hC);
      adv();

      // redirect in WAIT to 0x100, stale response two cycles later
      drv(0, 0, 32'h0, 1, 32'h100, 1);
      chk("rw_src", {31'b0, pc_src_o}, 32'h1);
      chk("rw_stall", {31'b0, pc_stall_o}, 32'h0);
      chk("rw_tgt", pc_target_o, 32'h100);
      adv();
      drv(0, 0, 32'h0, 0, 32'h0, 1);
      chk("rw_pc", pc, 32'h100);
      chk("rw_drop_req", {31'b0, imem_req_o}, 32'h0);
      chk("rw_drop_cnt0", {29'b0, drop_cnt_o}, 32'h0);
      adv();
      drv(0, 1, 32'hDEAD_BEEF, 0, 32'h0, 1);
      chk("rw_valid", {31'b0, dec_valid_o}, 32'h0);
      adv();
      drv(1, 0, 32'h0, 0, 32'h0, 1);
      chk("rw_addr", imem_addr_o, 32'h100);
      chk("rw_cnt", {29'b0, drop_cnt_o}, 32'h1);
      chk("rw_no_stale", dec_instr_o, 32'h13);
      chk("rw_no_valid", {31'b0, dec_valid_o}, 32'h0);
      adv();
      drv(0, 1, 32'h0040_0213, 0, 32'h0, 1);
      adv();

      // redirect in HOLD, decode not ready, target 0x203
      drv(0, 0, 32'h0, 1, 32'h203, 0);
      chk("rh_pc", dec_pc_o, 32'h100);
      chk("rh_instr", dec_instr_o, 32'h0040_0213);
      chk("rh_tgt", pc_target_o, 32'h200);
      adv();
      drv(1, 0, 32'h0, 0, 32'h0, 1);
      chk("rh_valid", {31'b0, dec_valid_o}, 32'h0);
      chk("rh_addr", imem_addr_o, 32'h200);
      chk("rh_cnt", {29'b0, drop_cnt_o}, 32'h1);
      adv();

      // two redirects while a stale request is pending
      drv(0, 0, 32'h0, 1, 32'h40, 1);           // WAIT -> DROP
      adv();
      drv(0, 0, 32'h0, 1, 32'h80, 1);           // DROP, second redirect
      chk("dd_req", {31'b0, imem_req_o}, 32'h0);
      adv();
      drv(0, 1, 32'hBAD0_0000, 0, 32'h0, 1);
      chk("dd_pc", pc, 32'h80);
      chk("dd_cnt_pend", {29'b0, drop_cnt_o}, 32'h1);
      adv();
      drv(1, 0, 32'h0, 0, 32'h0, 1);
      chk("dd_addr", imem_addr_o, 32'h80);
      chk("dd_cnt", {29'b0, drop_cnt_o}, 32'h2);
      adv();

      // redirect in WAIT coinciding with the response
      drv(0, 1, 32'hBAD1_0000, 1, 32'h300, 1);
      adv();
      drv(1, 1, 32'hBAD2_0000, 1, 32'h400, 1);  // REQ: stray rvalid ignored, gnt+redirect
      chk("wr_addr", imem_addr_o, 32'h300);
      chk("wr_cnt", {29'b0, drop_cnt_o}, 32'h3);
      chk("wr_valid", {31'b0, dec_valid_o}, 32'h0);
      adv();
      drv(0, 1, 32'hBAD3_0000, 0, 32'h0, 1);    // DROP
      chk("rg_req", {31'b0, imem_req_o}, 32'h0);
      chk("rg_cnt_pend", {29'b0, drop_cnt_o}, 32'h3);
      adv();
      drv(0, 0, 32'h0, 0, 32'h0, 1);
      chk("rg_addr", imem_addr_o, 32'h400);
      chk("rg_cnt", {29'b0, drop_cnt_o}, 32'h4);

      // saturation of the 3-bit counter
      for (int k = 0; k < 4; k++) begin
         drv(1, 0, 32'h0, 1, 32'h500 + 32'(k) * 32'h10, 1);
         adv();
         drv(0, 1, 32'hBAD4_0000, 0, 32'h0, 1);
         adv();
         drv(0, 0, 32'h0, 0, 32'h0, 1);
         chk("sat_cnt", {29'b0, drop_cnt_o}, (k < 3) ? 32'(5 + k) : 32'h7);
      end

      // reset mid-fetch, late response ignored
      drv(1, 0, 32'h0, 0, 32'h0, 1);
      adv();
      rst_n = 1'b0;
      drv(0, 0, 32'h0, 0, 32'h0, 1);
      chk("mr_stall", {31'b0, pc_stall_o}, 32'h1);
      adv();
      rst_n = 1'b1;
      drv(0, 1, 32'hBAD5_0000, 0, 32'h0, 1);
      chk("mr_idle_req", {31'b0, imem_req_o}, 32'h0);
      chk("mr_cnt", {29'b0, drop_cnt_o}, 32'h0);
      adv();
      drv(1, 0, 32'h0, 0, 32'h0, 1);
      chk("mr_req", {31'b0, imem_req_o}, 32'h1);
      chk("mr_addr", imem_addr_o, 32'h0);
      chk("mr_valid", {31'b0, dec_valid_o}, 32'h0);
      adv();
      drv(0, 1, 32'h0050_0293, 0, 32'h0, 1);
      adv();
      drv(0, 0, 32'h0, 0, 32'h0, 1);
      chk("mr_dvalid", {31'b0, dec_valid_o}, 32'h1);
      chk("mr_dpc", dec_pc_o, 32'h0);
      chk("mr_dinstr", dec_instr_o, 32'h0050_0293);
      adv();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
